// File: rtl/fwdcombine_n.sv
// N-input forwarder combiner: round-robin arbitration among channels with a
// registered grant that is held for a whole packet and released on done.
module fwdcombine_n #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int PLEN_WIDTH = ADDR_WIDTH + 1,
    localparam int SEL_W     = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    // channel side
    output logic [N*ADDR_WIDTH-1:0]    forwarder_rd_addr_in,
    input  logic [N*DATA_WIDTH-1:0]    forwarder_rd_data_in,
    output logic [N-1:0]               forwarder_rd_en_in,
    output logic [N-1:0]               forwarder_done_in,
    input  logic [N-1:0]               ready_for_forwarder_in,
    input  logic [N*PLEN_WIDTH-1:0]    len_to_forwarder_in,
    // upstream side
    input  logic [ADDR_WIDTH-1:0]      forwarder_rd_addr,
    output logic [DATA_WIDTH-1:0]      forwarder_rd_data,
    input  logic                       forwarder_rd_en,
    input  logic                       forwarder_done,
    output logic                       ready_for_forwarder,
    output logic [PLEN_WIDTH-1:0]      len_to_forwarder,
    output logic [SEL_W-1:0]           grant_idx,
    // debug: 0 = IDLE, 1 = GRANTED
    output logic                       dbg_state
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  last_q, last_d;

    logic              found;
    logic [SEL_W-1:0]  pick;
    int unsigned       idx;

    // Rotating priority scan starting just after the last granted channel.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!found && ready_for_forwarder_in[idx]) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANTED;
                    sel_d   = pick;
                    last_d  = pick;
                end
            end
            GRANTED: begin
                if (forwarder_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Steering depends only on registered state, never on the ready inputs.
    always_comb begin
        forwarder_rd_addr_in = '0;
        forwarder_rd_en_in   = '0;
        forwarder_done_in    = '0;
        forwarder_rd_data    = '0;
        ready_for_forwarder  = 1'b0;
        len_to_forwarder     = '0;
        if (state_q == GRANTED) begin
            forwarder_rd_addr_in[int'(sel_q)*ADDR_WIDTH +: ADDR_WIDTH] = forwarder_rd_addr;
            forwarder_rd_en_in[sel_q] = forwarder_rd_en;
            forwarder_done_in[sel_q]  = forwarder_done;
            forwarder_rd_data   = forwarder_rd_data_in[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
            ready_for_forwarder = 1'b1;
            len_to_forwarder    = len_to_forwarder_in[int'(sel_q)*PLEN_WIDTH +: PLEN_WIDTH];
        end
    end

    assign grant_idx = sel_q;
    assign dbg_state = (state_q == GRANTED);

endmodule

// File: tb/tb_fwdcombine_n.sv
// Directed self-checking bench for fwdcombine_n with N=4.
module tb_fwdcombine_n;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 10;
    localparam int PW = AW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] forwarder_rd_addr_in;
    logic [N*DW-1:0] forwarder_rd_data_in;
    logic [N-1:0]    forwarder_rd_en_in;
    logic [N-1:0]    forwarder_done_in;
    logic [N-1:0]    ready_for_forwarder_in;
    logic [N*PW-1:0] len_to_forwarder_in;
    logic [AW-1:0]   forwarder_rd_addr;
    logic [DW-1:0]   forwarder_rd_data;
    logic            forwarder_rd_en;
    logic            forwarder_done;
    logic            ready_for_forwarder;
    logic [PW-1:0]   len_to_forwarder;
    logic [1:0]      grant_idx;
    logic            dbg_state;

    logic [DW-1:0]   exp_data [N];
    logic [PW-1:0]   exp_len  [N];

    int checks   = 0;
    int failures = 0;

    fwdcombine_n #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PLEN_WIDTH(PW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .forwarder_rd_addr_in   (forwarder_rd_addr_in),
        .forwarder_rd_data_in   (forwarder_rd_data_in),
        .forwarder_rd_en_in     (forwarder_rd_en_in),
        .forwarder_done_in      (forwarder_done_in),
        .ready_for_forwarder_in (ready_for_forwarder_in),
        .len_to_forwarder_in    (len_to_forwarder_in),
        .forwarder_rd_addr      (forwarder_rd_addr),
        .forwarder_rd_data      (forwarder_rd_data),
        .forwarder_rd_en        (forwarder_rd_en),
        .forwarder_done         (forwarder_done),
        .ready_for_forwarder    (ready_for_forwarder),
        .len_to_forwarder       (len_to_forwarder),
        .grant_idx              (grant_idx),
        .dbg_state              (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 64'(ready_for_forwarder), 64'd0);
        check({tag, "_len"}, 64'(len_to_forwarder), 64'd0);
        check({tag, "_data"}, forwarder_rd_data, 64'd0);
        check({tag, "_done_in"}, 64'(forwarder_done_in), 64'd0);
        check({tag, "_rd_en_in"}, 64'(forwarder_rd_en_in), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    task automatic check_grant(input string tag, input int idx);
        check({tag, "_ready"}, 64'(ready_for_forwarder), 64'd1);
        check({tag, "_grant"}, 64'(grant_idx), 64'(idx));
        check({tag, "_len"}, 64'(len_to_forwarder), 64'(exp_len[idx]));
        check({tag, "_state"}, 64'(dbg_state), 64'd1);
    endtask

    // Pulse done on the currently granted channel idx and confirm release.
    task automatic release_grant(input string tag, input int idx);
        forwarder_done = 1'b1;
        #1;
        check({tag, "_done_in"}, 64'(forwarder_done_in), 64'(1 << idx));
        step();
        forwarder_done = 1'b0;
        #1;
        check({tag, "_rel_ready"}, 64'(ready_for_forwarder), 64'd0);
        check({tag, "_rel_done_in"}, 64'(forwarder_done_in), 64'd0);
    endtask

    initial begin
        exp_data[0] = 64'hC0DE_0000_0BAD_0000;
        exp_data[1] = 64'hC0DE_0001_0BAD_0011;
        exp_data[2] = 64'hC0DE_0002_0BAD_0022;
        exp_data[3] = 64'hC0DE_0003_0BAD_0033;
        exp_len[0]  = 11'd20;
        exp_len[1]  = 11'd37;
        exp_len[2]  = 11'd64;
        exp_len[3]  = 11'd100;
        for (int i = 0; i < N; i++) begin
            forwarder_rd_data_in[i*DW +: DW] = exp_data[i];
            len_to_forwarder_in[i*PW +: PW]  = exp_len[i];
        end

        // Reset with every channel ready.
        rst                    = 1'b1;
        ready_for_forwarder_in = 4'b1111;
        forwarder_rd_addr      = '0;
        forwarder_rd_en        = 1'b0;
        forwarder_done         = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();

        // Round robin with all channels continuously ready.
        for (int k = 0; k <= N; k++) begin
            check_grant($sformatf("rr%0d", k), k % N);
            for (int c = 0; c < 3; c++) begin
                step();
                check($sformatf("rr%0d_hold%0d", k, c), 64'(grant_idx), 64'(k % N));
            end
            if (k == N) ready_for_forwarder_in = 4'b0000;
            release_grant($sformatf("rr%0d", k), k % N);
            step();
        end
        check_idle("rr_end");

        // Single channel: ch2 only.
        ready_for_forwarder_in = 4'b0100;
        step();
        check_grant("single", 2);
        ready_for_forwarder_in = 4'b0000;
        forwarder_rd_addr      = 10'd5;
        forwarder_rd_en        = 1'b1;
        #1;
        check("single_rd_addr_in", 64'(forwarder_rd_addr_in), 64'(40'd5 << 20));
        check("single_rd_en_in", 64'(forwarder_rd_en_in), 64'b0100);
        check("single_rd_data", forwarder_rd_data, exp_data[2]);
        forwarder_rd_en   = 1'b0;
        forwarder_rd_addr = '0;
        release_grant("single", 2);
        step();
        check_idle("single_after");

        // Hold under contention: ch1 granted, others become ready mid-packet.
        ready_for_forwarder_in = 4'b0010;
        step();
        check_grant("hold", 1);
        ready_for_forwarder_in = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("hold_keep%0d", c), 64'(grant_idx), 64'd1);
        end
        release_grant("hold", 1);
        step();
        check_grant("hold_next", 2);
        ready_for_forwarder_in = 4'b0011;
        release_grant("hold_next", 2);
        step();
        check_grant("hold_wrap", 0);
        ready_for_forwarder_in = 4'b0000;
        release_grant("hold_wrap", 0);
        step();

        // Spurious done / rd_en while idle.
        forwarder_done  = 1'b1;
        forwarder_rd_en = 1'b1;
        #1;
        check_idle("spurious");
        step();
        forwarder_done  = 1'b0;
        forwarder_rd_en = 1'b0;
        #1;
        check_idle("spurious_after");

        // Granted channel drops ready mid-packet: grant is held.
        ready_for_forwarder_in = 4'b1000;
        step();
        check_grant("drop", 3);
        ready_for_forwarder_in = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            check_grant($sformatf("drop_held%0d", c), 3);
        end
        check("drop_data", forwarder_rd_data, exp_data[3]);
        release_grant("drop", 3);
        step();
        check_idle("drop_after");

        // Reset mid-grant: no done pulse, priority restarts at ch0.
        ready_for_forwarder_in = 4'b0010;
        step();
        check_grant("rstmid", 1);
        rst = 1'b1;
        step();
        check_idle("rstmid_reset");
        rst                    = 1'b0;
        ready_for_forwarder_in = 4'b1111;
        step();
        check_grant("rstmid_next", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
